// File: rtl/adv_pkg.sv
// Shared types for the adventure-game FSMs: room encoding, map size, direction indices.
// Purely declarative; no timing or backpressure.
package adv_pkg;

    typedef enum logic [2:0] {
        CAVE   = 3'd0,
        TUNNEL = 3'd1,
        RIVER  = 3'd2,
        STASH  = 3'd3,
        DEN    = 3'd4,
        VAULT  = 3'd5,
        GRAVE  = 3'd6
    } room_t;

    localparam int ROOM_N = 7;

    // Bit positions of the direction buttons inside the packed rise vector.
    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    function automatic logic [ROOM_N-1:0] room_onehot(input room_t r);
        logic [ROOM_N-1:0] oh;
        oh = '0;
        case (r)
            CAVE:    oh[0] = 1'b1;
            TUNNEL:  oh[1] = 1'b1;
            RIVER:   oh[2] = 1'b1;
            STASH:   oh[3] = 1'b1;
            DEN:     oh[4] = 1'b1;
            VAULT:   oh[5] = 1'b1;
            GRAVE:   oh[6] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/dir_edge.sv
// Rising-edge detect on the four direction buttons, plus exactly-one-rise qualifier.
// Rise is combinational off the current level vs. a one-cycle history; no backpressure.
module dir_edge (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] dirs,
    output logic [3:0] rise,
    output logic       one_hot_valid
);

    logic [3:0] prev;

    // History resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 4'hF;
        end else begin
            prev <= dirs;
        end
    end

    assign rise          = dirs & ~prev;
    assign one_hot_valid = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);

endmodule

// File: rtl/room_fsm.sv
// Room-navigation FSM: single button presses move through the seven-room map; DEN resolves on v.
// Moves take effect one cycle after the press; Moore outputs; no backpressure.
module room_fsm
    import adv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             n,
    input  logic             s,
    input  logic             e,
    input  logic             w,
    input  logic             v,
    output logic [6:0]       room,
    output logic             sw,
    output logic             win,
    output logic             die,
    output logic [CNT_W-1:0] moves
);

    room_t            state;
    room_t            state_nxt;
    logic             move_ok;
    logic [3:0]       rise;
    logic             req;
    logic [CNT_W-1:0] moves_q;

    dir_edge u_dir_edge (
        .clk           (clk),
        .reset_n       (reset_n),
        .dirs          ({w, e, s, n}),
        .rise          (rise),
        .one_hot_valid (req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CAVE;
            moves_q <= '0;
        end else begin
            state <= state_nxt;
            if (move_ok && (moves_q != {CNT_W{1'b1}})) begin
                moves_q <= moves_q + CNT_W'(1);
            end
        end
    end

    // move_ok flags only map moves; the DEN resolution is deliberately uncounted.
    always_comb begin
        state_nxt = state;
        move_ok   = 1'b0;
        case (state)
            CAVE: begin
                if (req && rise[DIR_E]) begin
                    state_nxt = TUNNEL;
                    move_ok   = 1'b1;
                end
            end
            TUNNEL: begin
                if (req && rise[DIR_W]) begin
                    state_nxt = CAVE;
                    move_ok   = 1'b1;
                end else if (req && rise[DIR_S]) begin
                    state_nxt = RIVER;
                    move_ok   = 1'b1;
                end
            end
            RIVER: begin
                if (req && rise[DIR_N]) begin
                    state_nxt = TUNNEL;
                    move_ok   = 1'b1;
                end else if (req && rise[DIR_W]) begin
                    state_nxt = STASH;
                    move_ok   = 1'b1;
                end else if (req && rise[DIR_E]) begin
                    state_nxt = DEN;
                    move_ok   = 1'b1;
                end
            end
            STASH: begin
                if (req && rise[DIR_E]) begin
                    state_nxt = RIVER;
                    move_ok   = 1'b1;
                end
            end
            DEN: begin
                state_nxt = v ? VAULT : GRAVE;
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    assign room  = room_onehot(state);
    assign sw    = (state == STASH);
    assign win   = (state == VAULT);
    assign die   = (state == GRAVE);
    assign moves = moves_q;

endmodule

// File: tb/tb_room_fsm.sv
module tb_room_fsm;

    localparam logic [6:0] R_CAVE   = 7'b0000001;
    localparam logic [6:0] R_TUNNEL = 7'b0000010;
    localparam logic [6:0] R_RIVER  = 7'b0000100;
    localparam logic [6:0] R_STASH  = 7'b0001000;
    localparam logic [6:0] R_DEN    = 7'b0010000;
    localparam logic [6:0] R_VAULT  = 7'b0100000;
    localparam logic [6:0] R_GRAVE  = 7'b1000000;

    localparam int BN = 0;
    localparam int BS = 1;
    localparam int BE = 2;
    localparam int BW = 3;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn;
    logic       v;

    logic [6:0] room;
    logic       sw, win, die;
    logic [7:0] moves;

    logic [6:0] room2;
    logic       sw2, win2, die2;
    logic [1:0] moves2;

    int n_cmp;
    int n_bad;

    room_fsm #(.CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .n(btn[BN]), .s(btn[BS]), .e(btn[BE]), .w(btn[BW]), .v(v),
        .room(room), .sw(sw), .win(win), .die(die), .moves(moves)
    );

    room_fsm #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .n(btn[BN]), .s(btn[BS]), .e(btn[BE]), .w(btn[BW]), .v(v),
        .room(room2), .sw(sw2), .win(win2), .die(die2), .moves(moves2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int dir);
        btn      = 4'b0000;
        btn[dir] = 1'b1;
        step();
        btn = 4'b0000;
    endtask

    task automatic do_reset();
        btn     = 4'b0000;
        v       = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        btn     = 4'b0001;
        v       = 1'b0;
        reset_n = 1'b0;
        #2;
        n_cmp++; if (room !== R_CAVE) begin n_bad++; $display("FAIL reset_room: got %b want %b", room, R_CAVE); end
        n_cmp++; if ({sw, win, die} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {sw, win, die}); end
        n_cmp++; if (moves !== 8'd0) begin n_bad++; $display("FAIL reset_moves: got %0d want 0", moves); end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (room !== R_CAVE || moves !== 8'd0) begin n_bad++; $display("FAIL held_n_after_reset[%0d]: got room %b moves %0d want %b 0", i, room, moves, R_CAVE); end
        end
        btn = 4'b0000;
        step();
    endtask

    task automatic test_path_to_stash();
        pulse(BE);
        n_cmp++; if (room !== R_TUNNEL || moves !== 8'd1) begin n_bad++; $display("FAIL move_e: got %b/%0d want %b/1", room, moves, R_TUNNEL); end
        step(); step();
        pulse(BS);
        n_cmp++; if (room !== R_RIVER || moves !== 8'd2 || sw !== 1'b0) begin n_bad++; $display("FAIL move_s: got %b/%0d sw %b want %b/2 sw 0", room, moves, sw, R_RIVER); end
        step(); step();
        pulse(BW);
        n_cmp++; if (room !== R_STASH || moves !== 8'd3 || sw !== 1'b1) begin n_bad++; $display("FAIL move_w: got %b/%0d sw %b want %b/3 sw 1", room, moves, sw, R_STASH); end
        step();
        n_cmp++; if (sw !== 1'b1) begin n_bad++; $display("FAIL sw_hold: got %b want 1", sw); end
    endtask

    task automatic test_win();
        pulse(BE);
        n_cmp++; if (room !== R_RIVER || moves !== 8'd4 || sw !== 1'b0) begin n_bad++; $display("FAIL stash_exit: got %b/%0d sw %b want %b/4 sw 0", room, moves, sw, R_RIVER); end
        step();
        v = 1'b1;
        pulse(BE);
        n_cmp++; if (room !== R_DEN || moves !== 8'd5) begin n_bad++; $display("FAIL enter_den: got %b/%0d want %b/5", room, moves, R_DEN); end
        step();
        n_cmp++; if (room !== R_VAULT || win !== 1'b1 || die !== 1'b0 || moves !== 8'd5) begin n_bad++; $display("FAIL vault: got %b win %b die %b moves %0d want %b 1 0 5", room, win, die, moves, R_VAULT); end
        for (int i = 0; i < 12; i++) begin
            btn = 4'($urandom);
            v   = 1'($urandom);
            step();
            n_cmp++; if (room !== R_VAULT || win !== 1'b1 || moves !== 8'd5) begin n_bad++; $display("FAIL vault_hold[%0d]: got %b win %b moves %0d want %b 1 5", i, room, win, moves, R_VAULT); end
        end
    endtask

    task automatic test_die();
        do_reset();
        pulse(BE); step();
        pulse(BS); step();
        v = 1'b0;
        pulse(BE);
        n_cmp++; if (room !== R_DEN || moves !== 8'd3) begin n_bad++; $display("FAIL den2: got %b/%0d want %b/3", room, moves, R_DEN); end
        btn = 4'b0001;   // rise during DEN must be ignored
        step();
        n_cmp++; if (room !== R_GRAVE || die !== 1'b1 || win !== 1'b0 || moves !== 8'd3) begin n_bad++; $display("FAIL grave: got %b die %b win %b moves %0d want %b 1 0 3", room, die, win, moves, R_GRAVE); end
        btn = 4'b0000;
        step();
        pulse(BN);
        n_cmp++; if (room !== R_GRAVE || moves !== 8'd3) begin n_bad++; $display("FAIL grave_hold: got %b/%0d want %b/3", room, moves, R_GRAVE); end
    endtask

    task automatic test_multi_press();
        do_reset();
        pulse(BE); step();
        pulse(BS); step();
        btn = 4'b0101;   // n and e together
        step();
        n_cmp++; if (room !== R_RIVER || moves !== 8'd2) begin n_bad++; $display("FAIL double_rise: got %b/%0d want %b/2", room, moves, R_RIVER); end
        btn = 4'b0000;
        step();
        pulse(BE);
        n_cmp++; if (room !== R_DEN || moves !== 8'd3) begin n_bad++; $display("FAIL single_after_double: got %b/%0d want %b/3", room, moves, R_DEN); end
        step();
        n_cmp++; if (room !== R_GRAVE || die !== 1'b1) begin n_bad++; $display("FAIL den_to_grave: got %b die %b want %b 1", room, die, R_GRAVE); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn = 4'b0100;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (room !== R_TUNNEL || moves !== 8'd1) begin n_bad++; $display("FAIL held_e: got %b/%0d want %b/1", room, moves, R_TUNNEL); end
        btn = 4'b0000;
        step();
        pulse(BW);
        pulse(BE);
        n_cmp++; if (room !== R_TUNNEL || moves !== 8'd3) begin n_bad++; $display("FAIL back_to_back: got %b/%0d want %b/3", room, moves, R_TUNNEL); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(BE);
        n_cmp++; if (room !== R_TUNNEL || moves !== 8'd1) begin n_bad++; $display("FAIL pre_async: got %b/%0d want %b/1", room, moves, R_TUNNEL); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (room !== R_CAVE || moves !== 8'd0) begin n_bad++; $display("FAIL async_reset: got %b/%0d want %b/0", room, moves, R_CAVE); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(i % 2 == 0 ? BE : BW);
            if (i == 2) begin
                n_cmp++; if (moves2 !== 2'd3) begin n_bad++; $display("FAIL sat_reach: got %0d want 3", moves2); end
            end
        end
        n_cmp++; if (moves2 !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %0d want 3", moves2); end
        n_cmp++; if (moves !== 8'd5 || room2 !== R_TUNNEL) begin n_bad++; $display("FAIL sat_ref: got moves %0d room2 %b want 5 %b", moves, room2, R_TUNNEL); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        btn     = 4'b0000;
        v       = 1'b0;
        reset_n = 1'b1;
        #1;
        test_reset();
        test_path_to_stash();
        test_win();
        test_die();
        test_multi_press();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/room_fsm.md
# room_fsm

Room-navigation state machine for the adventure game. Converts player direction buttons into moves through a fixed seven-room map. Drives the sword-found signal consumed by the downstream sword FSM, and consumes that FSM's vorpal-sword flag to resolve the dragon encounter. Also reports win/die status and a count of accepted moves.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the move counter.

**Ports**
- `clk`, input, 1: system clock; all state updates on rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `n`, `s`, `e`, `w`, input, 1 each: direction buttons, level, synchronous to `clk`.
- `v`, input, 1: vorpal sword held, from the sword FSM.
- `room`, output, 7: one-hot current room. Bit 0 CAVE, 1 TUNNEL, 2 RIVER, 3 STASH, 4 DEN, 5 VAULT, 6 GRAVE.
- `sw`, output, 1: high while in STASH.
- `win`, output, 1: high while in VAULT.
- `die`, output, 1: high while in GRAVE.
- `moves`, output, `CNT_W`: accepted-move count, saturating.

## Operation

**Edge detection**
- Each direction has a previous-value register.
- `rise_x = x & ~prev_x`.

**Move validity**
- A move request exists when exactly one `rise_x` is high.
- Two or more simultaneous rises are ignored entirely: no move, no count.

**Transitions on a move request** (any direction not listed causes no change and no count)
- CAVE: E -> TUNNEL.
- TUNNEL: W -> CAVE; S -> RIVER.
- RIVER: N -> TUNNEL; W -> STASH; E -> DEN.
- STASH: E -> RIVER.

**Non-input states**
- DEN is transient. On the next clock, regardless of direction inputs, go to VAULT if `v`=1, else GRAVE.
- VAULT and GRAVE are terminal. They hold until `reset_n` is asserted. All inputs are ignored there.

**Counter**
- `moves` increments by 1 only on an accepted direction transition.
- The DEN resolution is not counted.
- `moves` saturates at 2^CNT_W−1.

**Outputs**
- All outputs are Moore: decoded from registered state and counter only. No combinational path from inputs to outputs.

## Timing

**Reset values**
- state = CAVE, `room` = 7'b0000001.
- `sw` = `win` = `die` = 0, `moves` = 0.
- prev registers = 1. A button held through reset release is not a press; it must be released and pressed again.

**Latency**
- A rise seen in cycle k changes `room` in cycle k+1.
- A held button produces exactly one move.
- A press in cycle k+1 may cause a second move in cycle k+2.

**DEN**
- Occupies exactly one cycle.
- `v` is sampled in that cycle.
- The end state appears one cycle after DEN.
- A rise during the DEN cycle is discarded.

**`sw` and `win`/`die` timing**
- `sw` asserts the cycle after the move into STASH.
- `sw` deasserts the cycle after the move out of STASH.
- `win`/`die` assert in the cycle after DEN and stay high until reset.

**Reset mid-operation**
- Asynchronous assertion forces all reset values immediately, with no clock needed.
- Release is synchronised externally; no requirement beyond clean deassertion.

## Structure

**Package `adv_pkg`**
- `room_t`: 3-bit enum with values CAVE=0, TUNNEL, RIVER, STASH, DEN, VAULT, GRAVE.
- `ROOM_N` = 7.
- Shared with the sword FSM and top level.

**Sub-module `dir_edge`**
- Holds the four prev registers (reset to 1) and outputs `rise[3:0]`.
- Also outputs `one_hot_valid`, true when exactly one bit of `rise` is set.
- Main FSM: one `always_ff` for state and counter, one `always_comb` for next-state, and continuous output decode.

## Test plan

1. Reset with `n`=1 held, release `reset_n`, keep `n`=1 for 5 cycles -> `room`=0000001, `moves`=0 throughout.
2. Pulse E, S, W (one cycle each, gaps of 2) -> `room` goes CAVE→TUNNEL→RIVER→STASH. `sw`=1 from the cycle after the W pulse. `moves`=3.
3. From STASH, pulse E then E with `v`=1 during the DEN cycle -> RIVER, DEN for one cycle, then VAULT. `win`=1 and stays high for 10+ cycles of random button activity. `moves`=5.
4. Same path with `v`=0 in DEN -> GRAVE, `die`=1, `win`=0.
5. In RIVER, raise `n` and `e` in the same cycle -> no room change, no count. Then release both and raise `e` alone -> DEN.
6. Assert `reset_n`=0 asynchronously mid-cycle while in TUNNEL with `moves`=1 -> `room`=CAVE and `moves`=0 before the next clock edge.
7. With `CNT_W`=2, toggle CAVE↔TUNNEL five times -> `moves` holds at 3.
